// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters (round-robin); ALU_ARB_STATS_EN adds grant counters.
// Latency: rsp valid one cycle after req_ready; 1 op/cycle while the owner keeps its rsp_ready high.
// Backpressure: a held response blocks all new grants until its owner consumes it.
module alu_share_arb #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [SEL_W-1:0] req1_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [SEL_W-1:0] alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]      gnt0_cnt,
    output logic [15:0]      gnt1_cnt
`endif
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_q, rr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             owner_rdy;
    logic             can_accept;
    logic             gnt0, gnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        data_d     = data_q;
        alu_sel    = '0;
        alu_a      = '0;
        alu_b      = '0;

        // Only the owner of the held response can free the slot.
        owner_rdy  = owner_q ? rsp1_ready : rsp0_ready;
        can_accept = (state_q == IDLE) || owner_rdy;

        gnt0 = can_accept && req0_valid && (!req1_valid || !rr_q);
        gnt1 = can_accept && req1_valid && (!req0_valid ||  rr_q);

        if (gnt0) begin
            alu_sel = req0_sel;
            alu_a   = req0_a;
            alu_b   = req0_b;
        end else if (gnt1) begin
            alu_sel = req1_sel;
            alu_a   = req1_a;
            alu_b   = req1_b;
        end

        if (gnt0 || gnt1) begin
            state_d = HOLD;
            owner_d = gnt1;
            rr_d    = gnt0;
            data_d  = alu_result;
        end else if (state_q == HOLD && owner_rdy) begin
            state_d = IDLE;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp_data   = data_q;
    assign rsp0_valid = (state_q == HOLD) && !owner_q;
    assign rsp1_valid = (state_q == HOLD) &&  owner_q;

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else begin
            if (gnt0 && gnt0_cnt != 16'hFFFF) gnt0_cnt <= gnt0_cnt + 16'd1;
            if (gnt1 && gnt1_cnt != 16'hFFFF) gnt1_cnt <= gnt1_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus random traffic against a queue-free reference model.
module tb_alu_share_arb;
    localparam int WIDTH = 32;
    localparam int SEL_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [SEL_W-1:0] req0_sel, req1_sel, alu_sel;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result, rsp_data;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]      gnt0_cnt, gnt1_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state: held response, its owner and data, favoured requester.
    bit               m_hold, m_owner, m_ptr;
    logic [WIDTH-1:0] m_data;
    int               e_win;

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [SEL_W-1:0] s,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (s)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            default: return a;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_sel, alu_a, alu_b);

    alu_share_arb #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_data(rsp_data),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready)
`ifdef ALU_ARB_STATS_EN
        , .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_sel = '0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_sel = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1; rsp1_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic model_eval();
        bit ordy;
        ordy  = m_owner ? rsp1_ready : rsp0_ready;
        e_win = -1;
        if (!m_hold || ordy) begin
            if (req0_valid && req1_valid) e_win = m_ptr ? 1 : 0;
            else if (req0_valid)          e_win = 0;
            else if (req1_valid)          e_win = 1;
        end
    endtask

    task automatic model_commit();
        bit ordy;
        ordy = m_owner ? rsp1_ready : rsp0_ready;
        if (e_win == 0) begin
            m_hold = 1; m_owner = 0; m_ptr = 1;
            m_data = alu_fn(req0_sel, req0_a, req0_b);
        end else if (e_win == 1) begin
            m_hold = 1; m_owner = 1; m_ptr = 0;
            m_data = alu_fn(req1_sel, req1_a, req1_b);
        end else if (m_hold && ordy) begin
            m_hold = 0;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp0_valid: got %b want 0", rsp0_valid); end
        total++; if (rsp1_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp1_valid: got %b want 0", rsp1_valid); end
        total++; if (rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data: got %0h want 0", rsp_data); end
        total++; if (alu_sel !== '0) begin bad++; $display("FAIL reset_alu_sel: got %0h want 0", alu_sel); end
        tick();
        rst = 0;
        req0_valid = 1; req0_sel = 4'd2; req0_a = 32'hF0F0; req0_b = 32'h3C3C;
        req1_valid = 1; req1_sel = 4'd0; req1_a = 32'h1;    req1_b = 32'h2;
        @(negedge clk);
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL reset_first_grant: got %b%b want 10", req0_ready, req1_ready); end
        total++; if (alu_a !== 32'hF0F0) begin bad++; $display("FAIL reset_first_alu_a: got %0h want f0f0", alu_a); end
        tick();
        idle_inputs();
        @(negedge clk);
        total++; if (rsp0_valid !== 1'b1 || rsp_data !== 32'h3030) begin bad++; $display("FAIL reset_first_rsp: got v=%b d=%0h want v=1 d=3030", rsp0_valid, rsp_data); end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1; req0_sel = 4'd0; req0_a = 32'd5; req0_b = 32'd7;
        @(negedge clk);
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready); end
        total++; if ({alu_sel, alu_a, alu_b} !== {4'd0, 32'd5, 32'd7}) begin bad++; $display("FAIL single_alu_drive: got %0h/%0h/%0h want 0/5/7", alu_sel, alu_a, alu_b); end
        tick();
        req0_valid = 0;
        @(negedge clk);
        total++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL single_valid: got %b%b want 10", rsp0_valid, rsp1_valid); end
        total++; if (rsp_data !== 32'd12) begin bad++; $display("FAIL single_data: got %0d want 12", rsp_data); end
        total++; if ({alu_sel, alu_a, alu_b} !== '0) begin bad++; $display("FAIL single_alu_idle: got %0h/%0h/%0h want 0", alu_sel, alu_a, alu_b); end
        tick();
        @(negedge clk);
        total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL single_idle: got %b%b want 00", rsp0_valid, rsp1_valid); end
        tick();
    endtask

    task automatic test_back_to_back();
        int prev;
        do_reset();
        prev = -1;
        req0_valid = 1; req0_sel = 4'd0; req0_a = 32'd10; req0_b = 32'd3;
        req1_valid = 1; req1_sel = 4'd1; req1_a = 32'd10; req1_b = 32'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL b2b_grant[%0d]: got %b%b want %s", i, req0_ready, req1_ready, (i % 2 == 0) ? "10" : "01");
            end
            if (prev >= 0) begin
                total++;
                if ({rsp0_valid, rsp1_valid} !== ((prev == 0) ? 2'b10 : 2'b01) ||
                    rsp_data !== ((prev == 0) ? 32'd13 : 32'd7)) begin
                    bad++; $display("FAIL b2b_rsp[%0d]: got v=%b%b d=%0d want owner %0d", i, rsp0_valid, rsp1_valid, rsp_data, prev);
                end
            end
            prev = i % 2;
            tick();
        end
        idle_inputs();
        @(negedge clk);
        total++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_data !== 32'd7) begin bad++; $display("FAIL b2b_last: got v=%b%b d=%0d want 01 d=7", rsp0_valid, rsp1_valid, rsp_data); end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp1_ready = 0;
        req1_valid = 1; req1_sel = 4'd4; req1_a = 32'hF0F0; req1_b = 32'h0FF0;
        @(negedge clk);
        total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL bp_first_grant: got %b want 1", req1_ready); end
        tick();
        req1_valid = 0;
        req0_valid = 1; req0_sel = 4'd2; req0_a = 32'hFF; req0_b = 32'h0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (req0_ready !== 1'b0 || rsp1_valid !== 1'b1 || rsp_data !== 32'hFF00 || alu_sel !== '0) begin
                bad++; $display("FAIL bp_stall[%0d]: got rdy=%b v1=%b d=%0h sel=%0h want 0/1/ff00/0", i, req0_ready, rsp1_valid, rsp_data, alu_sel);
            end
            tick();
        end
        rsp1_ready = 1;
        @(negedge clk);
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL bp_release_grant: got %b want 1", req0_ready); end
        tick();
        req0_valid = 0;
        @(negedge clk);
        total++; if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp_data !== 32'h0F) begin bad++; $display("FAIL bp_release_rsp: got v=%b%b d=%0h want 10 d=f", rsp0_valid, rsp1_valid, rsp_data); end
        tick();
    endtask

    task automatic test_reset_hold();
        do_reset();
        rsp0_ready = 0;
        req0_valid = 1; req0_sel = 4'd3; req0_a = 32'd1; req0_b = 32'd2;
        tick();
        req0_valid = 0;
        @(negedge clk);
        total++; if (rsp0_valid !== 1'b1 || rsp_data !== 32'd3) begin bad++; $display("FAIL rsthold_pre: got v=%b d=%0h want 1 d=3", rsp0_valid, rsp_data); end
        tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        total++; if ({rsp0_valid, rsp1_valid} !== 2'b00 || rsp_data !== '0) begin bad++; $display("FAIL rsthold_drop: got v=%b%b d=%0h want 00 d=0", rsp0_valid, rsp1_valid, rsp_data); end
        tick();
        rsp0_ready = 1;
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL rsthold_ptr: got %b%b want 10", req0_ready, req1_ready); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [SEL_W-1:0] es;
        logic [WIDTH-1:0] ea, eb;
        do_reset();
        m_hold = 0; m_owner = 0; m_ptr = 0; m_data = '0;
        for (int i = 0; i < 400; i++) begin
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_valid = 1; req0_sel = SEL_W'($urandom_range(0, 7));
                req0_a = $urandom; req0_b = $urandom;
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_valid = 1; req1_sel = SEL_W'($urandom_range(0, 7));
                req1_a = $urandom; req1_b = $urandom;
            end
            @(negedge clk);
            model_eval();
            es = '0; ea = '0; eb = '0;
            if (e_win == 0) begin es = req0_sel; ea = req0_a; eb = req0_b; end
            if (e_win == 1) begin es = req1_sel; ea = req1_a; eb = req1_b; end
            total++;
            if ({req0_ready, req1_ready} !== {e_win == 0, e_win == 1}) begin
                bad++; $display("FAIL rand_ready[%0d]: got %b%b want winner %0d", i, req0_ready, req1_ready, e_win);
            end
            total++;
            if ({alu_sel, alu_a, alu_b} !== {es, ea, eb}) begin
                bad++; $display("FAIL rand_alu[%0d]: got %0h/%0h/%0h want %0h/%0h/%0h", i, alu_sel, alu_a, alu_b, es, ea, eb);
            end
            total++;
            if ({rsp0_valid, rsp1_valid} !== {m_hold && !m_owner, m_hold && m_owner}) begin
                bad++; $display("FAIL rand_valid[%0d]: got %b%b want hold=%0d owner=%0d", i, rsp0_valid, rsp1_valid, m_hold, m_owner);
            end
            if (m_hold) begin
                total++;
                if (rsp_data !== m_data) begin
                    bad++; $display("FAIL rand_data[%0d]: got %0h want %0h", i, rsp_data, m_data);
                end
            end
            model_commit();
            tick();
            if (e_win == 0) req0_valid = 0;
            if (e_win == 1) req1_valid = 0;
        end
        idle_inputs();
        tick();
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        @(negedge clk);
        total++; if (gnt0_cnt !== 16'd0 || gnt1_cnt !== 16'd0) begin bad++; $display("FAIL stats_reset: got %0h/%0h want 0/0", gnt0_cnt, gnt1_cnt); end
        tick();
        req1_valid = 1; req1_sel = 4'd0; req1_a = 32'd1; req1_b = 32'd1;
        repeat (3) tick();
        @(negedge clk);
        total++; if (gnt1_cnt !== 16'd3) begin bad++; $display("FAIL stats_count: got %0d want 3", gnt1_cnt); end
        repeat (70000 - 3) tick();
        req1_valid = 0;
        @(negedge clk);
        total++; if (gnt1_cnt !== 16'hFFFF || gnt0_cnt !== 16'd0) begin bad++; $display("FAIL stats_saturate: got %0h/%0h want 0/ffff", gnt0_cnt, gnt1_cnt); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_hold();
        test_random();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
